// File: rtl/msi_tx_engine.sv
// msi_tx_engine
// Builds the MSI Memory Write TLP (3DW or 4DW header, one data DW) on the
// 64-bit TRN transmit port. The port is shared with another TX engine
// through a tx_req/tx_grant handshake. Requests that arrive while a message
// is in flight coalesce into a single follow-up MSI.
module msi_tx_engine #(
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter logic [2:0]  MSI_TC         = 3'b000
) (
    input  logic        trn_clk,
    input  logic        reset,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n,
    output logic        tx_req,
    input  logic        tx_grant,
    input  logic        cfg_interrupt_msienable,
    input  logic [15:0] cfg_completer_id,
    input  logic [63:0] msi_message_addr_reg,
    input  logic [15:0] msi_message_data_reg,
    input  logic        irq_req,
    output logic        irq_busy,
    output logic [31:0] msi_sent_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_B0,
        S_B1,
        S_B2,
        S_GAP
    } state_t;

    state_t      r_state;
    logic [63:0] r_td;
    logic [7:0]  r_trem_n;
    logic        r_tsof_n;
    logic        r_teof_n;
    logic        r_tsrc_rdy_n;
    logic        r_tx_req;
    logic        r_irq_busy;
    logic [31:0] r_sent_cnt;
    logic        r_pending;
    logic [31:0] r_hold_cnt;

    // Message parameters frozen at request acceptance
    logic [63:0] r_addr;
    logic [15:0] r_data;
    logic [15:0] r_cid;

    logic        w_start;
    logic        w_beat_ok;
    logic        w_is_4dw;
    logic        w_hold_done;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_data_dw;

    assign w_start     = (irq_req | r_pending) & cfg_interrupt_msienable;
    assign w_beat_ok   = ~r_tsrc_rdy_n & ~trn_tdst_rdy_n;
    assign w_is_4dw    = |r_addr[63:32];
    assign w_hold_done = (r_hold_cnt + 32'd1) >= HOLDOFF_CYCLES;

    assign w_dw0 = {1'b0, (w_is_4dw ? 2'b11 : 2'b10), 5'b00000, 1'b0, MSI_TC,
                    4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    assign w_dw1 = {r_cid, 8'h00, 4'h0, 4'hF};
    // Payload is little-endian; TRN carries byte 0 in the top lane
    assign w_data_dw = {r_data[7:0], r_data[15:8], 16'h0000};

    assign trn_td         = r_td;
    assign trn_trem_n     = r_trem_n;
    assign trn_tsof_n     = r_tsof_n;
    assign trn_teof_n     = r_teof_n;
    assign trn_tsrc_rdy_n = r_tsrc_rdy_n;
    assign tx_req         = r_tx_req;
    assign irq_busy       = r_irq_busy;
    assign msi_sent_cnt   = r_sent_cnt;

    // Capture address/data/requester ID when a request is accepted; low address bits forced to zero
    always_ff @(posedge trn_clk) begin
        if (r_state == S_IDLE && w_start) begin
            r_addr <= msi_message_addr_reg & 64'hFFFF_FFFF_FFFF_FFFC;
            r_data <= msi_message_data_reg;
            r_cid  <= cfg_completer_id;
        end
    end

    // Main FSM: request the port, stream the header/payload beats, then enforce the holdoff gap
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_td         <= 64'h0;
            r_trem_n     <= 8'h00;
            r_tsof_n     <= 1'b1;
            r_teof_n     <= 1'b1;
            r_tsrc_rdy_n <= 1'b1;
            r_tx_req     <= 1'b0;
            r_irq_busy   <= 1'b0;
            r_sent_cnt   <= 32'h0;
            r_pending    <= 1'b0;
            r_hold_cnt   <= 32'h0;
        end else begin
            // IDLE either consumes the request or has nothing pending; disabling MSI drops any backlog
            if (!cfg_interrupt_msienable || r_state == S_IDLE) begin
                r_pending <= 1'b0;
            end else if (irq_req) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tx_req   <= 1'b1;
                        r_irq_busy <= 1'b1;
                        r_state    <= S_REQ;
                    end else begin
                        r_irq_busy <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (tx_grant) begin
                        r_td         <= {w_dw0, w_dw1};
                        r_trem_n     <= 8'h00;
                        r_tsof_n     <= 1'b0;
                        r_teof_n     <= 1'b1;
                        r_tsrc_rdy_n <= 1'b0;
                        r_state      <= S_B0;
                    end
                end

                S_B0: begin
                    if (w_beat_ok) begin
                        r_tsof_n <= 1'b1;
                        r_trem_n <= 8'h00;
                        if (w_is_4dw) begin
                            r_td     <= r_addr;
                            r_teof_n <= 1'b1;
                        end else begin
                            r_td     <= {r_addr[31:0], w_data_dw};
                            r_teof_n <= 1'b0;
                        end
                        r_state <= S_B1;
                    end
                end

                S_B1, S_B2: begin
                    if (w_beat_ok) begin
                        if (!r_teof_n) begin
                            // Final beat accepted: release the port and start the holdoff
                            r_tsrc_rdy_n <= 1'b1;
                            r_teof_n     <= 1'b1;
                            r_trem_n     <= 8'h00;
                            r_tx_req     <= 1'b0;
                            r_sent_cnt   <= r_sent_cnt + 32'd1;
                            r_hold_cnt   <= 32'h0;
                            r_state      <= S_GAP;
                        end else begin
                            // Second beat of a 4DW header went out; payload goes in the upper lane
                            r_td     <= {w_data_dw, 32'h0};
                            r_teof_n <= 1'b0;
                            r_trem_n <= 8'h0F;
                            r_state  <= S_B2;
                        end
                    end
                end

                S_GAP: begin
                    if (w_hold_done) begin
                        r_irq_busy <= w_start;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
